// File: rtl/clock_ctrl.sv
// Mode controller for the hh:mm:ss clock: seconds prescaler, button front-end, RUN/SET_MIN/SET_HR FSM.
// Optional button debounce filter is enabled by defining CLOCK_CTRL_DEBOUNCE_EN.
module clock_ctrl #(
    parameter int unsigned DIV           = 50_000_000,
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned DEB_CYCLES    = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_adv,
    input  logic       btn_disp,
    output logic       en_sec,
    output logic       sel_min,
    output logic       sel_hr,
    output logic       set,
    output logic       state,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_HR  = 2'b10
    } mode_t;

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    // Button bit order: [0] mode, [1] adv, [2] disp.
    logic [2:0] btn_raw, sync1, sync2, level, prev, ev;
    logic       mode_ev, adv_ev, disp_ev, any_ev;

    assign btn_raw = {btn_disp, btn_adv, btn_mode};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    filt;

    // NOTE: the counter array is tiny and sits in flops, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    // Registered rising-edge detect: one event per press however long it is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            ev   <= '0;
        end else begin
            prev <= level;
            ev   <= level & ~prev;
        end
    end

    assign mode_ev = ev[0];
    assign adv_ev  = ev[1];
    assign disp_ev = ev[2];
    assign any_ev  = |ev;

    logic [PW-1:0] pre_cnt;
    logic          tick;

    assign tick = (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pre_cnt <= '0;
        else      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end

    mode_t         mode_q;
    logic [TW-1:0] to_cnt;
    logic          saved_state;
    logic          timeout;

    assign timeout = tick && (to_cnt == TW'(TIMEOUT_TICKS - 1));
    assign mode    = mode_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q      <= RUN;
            en_sec      <= 1'b0;
            set         <= 1'b0;
            sel_min     <= 1'b1;
            sel_hr      <= 1'b1;
            state       <= 1'b1;
            saved_state <= 1'b1;
            to_cnt      <= '0;
        end else begin
            en_sec <= tick && (mode_q == RUN);
            set    <= 1'b0;
            case (mode_q)
                RUN: begin
                    to_cnt  <= '0;
                    sel_min <= 1'b1;
                    sel_hr  <= 1'b1;
                    if (mode_ev) begin
                        mode_q      <= SET_MIN;
                        sel_min     <= 1'b0;
                        saved_state <= state;
                        state       <= 1'b1;
                    end else if (disp_ev) begin
                        state <= ~state;
                    end
                end
                SET_MIN, SET_HR: begin
                    state <= 1'b1;
                    // Timeout outranks a simultaneous mode press; adv is dropped whenever the mode moves.
                    if (timeout) begin
                        mode_q  <= RUN;
                        sel_min <= 1'b1;
                        sel_hr  <= 1'b1;
                        state   <= saved_state;
                        to_cnt  <= '0;
                    end else if (mode_ev) begin
                        to_cnt <= '0;
                        if (mode_q == SET_MIN) begin
                            mode_q  <= SET_HR;
                            sel_min <= 1'b1;
                            sel_hr  <= 1'b0;
                        end else begin
                            mode_q  <= RUN;
                            sel_min <= 1'b1;
                            sel_hr  <= 1'b1;
                            state   <= saved_state;
                        end
                    end else begin
                        set <= adv_ev;
                        if (any_ev)    to_cnt <= '0;
                        else if (tick) to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    mode_q  <= RUN;
                    sel_min <= 1'b1;
                    sel_hr  <= 1'b1;
                    to_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus queues expected pulses/levels, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_clock_ctrl;

    localparam int DIV = 4;
`ifdef CLOCK_CTRL_DEBOUNCE_EN
    localparam int TO  = 20;
`else
    localparam int TO  = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode, btn_adv, btn_disp;
    logic       en_sec, sel_min, sel_hr, set, state;
    logic [1:0] mode;

    clock_ctrl #(
        .DIV          (DIV),
        .TIMEOUT_TICKS(TO),
        .DEB_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_adv (btn_adv),
        .btn_disp(btn_disp),
        .en_sec  (en_sec),
        .sel_min (sel_min),
        .sel_hr  (sel_hr),
        .set     (set),
        .state   (state),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int md;
        int sm;
        int sh;
        int st;
    } lvl_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   exp_en  [$];
    int   exp_set [$];
    lvl_t exp_lvl [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cyc %0d: actual %0d required %0d", name, cyc, act, req);
        end
    endtask

    task automatic push_en(input int from, input int upto);
        for (int c = from; c <= upto; c++)
            if (c % DIV == 0) exp_en.push_back(c);
    endtask

    task automatic push_lvl(input int c, input int md, input int sm, input int sh, input int st);
        lvl_t e;
        e.cyc = c; e.md = md; e.sm = sm; e.sh = sh; e.st = st;
        exp_lvl.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compares pulses and levels against the queues, away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (exp_en.size() > 0 && exp_en[0] < cyc)
                check("en_sec_missing", -1, exp_en.pop_front());
            if (en_sec) begin
                if (exp_en.size() == 0) check("en_sec_unexpected", cyc, -1);
                else                    check("en_sec_cycle", cyc, exp_en.pop_front());
            end
            if (exp_set.size() > 0 && exp_set[0] < cyc)
                check("set_missing", -1, exp_set.pop_front());
            if (set) begin
                if (exp_set.size() == 0) check("set_unexpected", cyc, -1);
                else                     check("set_cycle", cyc, exp_set.pop_front());
            end
            while (exp_lvl.size() > 0 && exp_lvl[0].cyc <= cyc) begin
                lvl_t e;
                e = exp_lvl.pop_front();
                check("lvl_cycle", cyc, e.cyc);
                check("mode", int'(mode), e.md);
                check("sel_min", int'(sel_min), e.sm);
                check("sel_hr", int'(sel_hr), e.sh);
                check("state", int'(state), e.st);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        btn_mode = 1'b0;
        btn_adv  = 1'b0;
        btn_disp = 1'b0;
        #22 rst = 1'b1;
`ifdef CLOCK_CTRL_DEBOUNCE_EN
        push_en(4, 16);
        push_lvl(1, 0, 1, 1, 1);
        wait_cyc(5);  btn_mode = 1'b1;
        push_lvl(16, 0, 1, 1, 1);
        push_lvl(17, 1, 0, 1, 1);
        wait_cyc(17); btn_mode = 1'b0;
        // Bounce: 3 clk on / 3 clk off never satisfies the 8-clk window.
        for (int k = 0; k < 4; k++) begin
            wait_cyc(20 + 6 * k); btn_adv = 1'b1;
            wait_cyc(23 + 6 * k); btn_adv = 1'b0;
        end
        wait_cyc(50); btn_adv = 1'b1;
        exp_set.push_back(62);
        push_lvl(62, 1, 0, 1, 1);
        wait_cyc(60); btn_adv = 1'b0;
        wait_cyc(75);
`else
        push_en(4, 84);
        push_lvl(1, 0, 1, 1, 1);
        // Display toggle: 4 clk after the press, single event while held.
        wait_cyc(21); btn_disp = 1'b1;
        push_lvl(24, 0, 1, 1, 1);
        push_lvl(25, 0, 1, 1, 0);
        push_lvl(70, 0, 1, 1, 0);
        wait_cyc(71); btn_disp = 1'b0;
        push_lvl(76, 0, 1, 1, 0);
        // Enter SET_MIN, then two advance pulses.
        wait_cyc(81); btn_mode = 1'b1;
        push_lvl(84, 0, 1, 1, 0);
        push_lvl(85, 1, 0, 1, 1);
        wait_cyc(83); btn_mode = 1'b0;
        wait_cyc(86); btn_adv = 1'b1;
        exp_set.push_back(90);
        wait_cyc(88); btn_adv = 1'b0;
        wait_cyc(92); btn_adv = 1'b1;
        exp_set.push_back(96);
        push_lvl(95, 1, 0, 1, 1);
        wait_cyc(94); btn_adv = 1'b0;
        // Mode and adv together: mode wins, no set pulse.
        wait_cyc(96); btn_mode = 1'b1; btn_adv = 1'b1;
        push_lvl(99, 1, 0, 1, 1);
        push_lvl(100, 2, 1, 0, 1);
        wait_cyc(98); btn_mode = 1'b0; btn_adv = 1'b0;
        // SET_HR idle: three ticks to timeout, saved display page restored.
        push_lvl(111, 2, 1, 0, 1);
        push_lvl(112, 0, 1, 1, 0);
        push_en(116, 124);
        wait_cyc(122); btn_mode = 1'b1;
        push_lvl(126, 1, 0, 1, 1);
        wait_cyc(124); btn_mode = 1'b0;
        wait_cyc(128);
        check("queue_en_before_reset", exp_en.size(), 0);
        check("queue_set_before_reset", exp_set.size(), 0);
        check("queue_lvl_before_reset", exp_lvl.size(), 0);
        // Asynchronous reset in the middle of SET_MIN.
        #2 rst = 1'b0;
        #1;
        check("rst_mode", int'(mode), 0);
        check("rst_sel_min", int'(sel_min), 1);
        check("rst_sel_hr", int'(sel_hr), 1);
        check("rst_state", int'(state), 1);
        check("rst_set", int'(set), 0);
        check("rst_en_sec", int'(en_sec), 0);
        push_en(4, 8);
        push_lvl(1, 0, 1, 1, 1);
        #4 rst = 1'b1;
        wait_cyc(10);
`endif
        check("queue_en_left", exp_en.size(), 0);
        check("queue_set_left", exp_set.size(), 0);
        check("queue_lvl_left", exp_lvl.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Mode controller for the hh:mm:ss clock datapath. Generates the one-second enable (`en_sec`), the per-counter input selects (`sel_min`, `sel_hr`), the manual-advance pulse (`set`) and the display select (`state`) from three raw push-buttons. It runs a RUN / SET_MIN / SET_HR state machine with a set-mode inactivity timeout. It sits between the board buttons and the clock datapath and drives that datapath's control inputs directly.

## Interface
- `DIV`, 50_000_000 — clk cycles per `en_sec` tick; ≥ 2.
- `TIMEOUT_TICKS`, 10 — ticks without button activity before a set mode falls back to RUN; ≥ 1.
- `DEB_CYCLES`, 500_000 — debounce stability window in clk cycles; used only with `CLOCK_CTRL_DEBOUNCE_EN`.

Ports:
- `clk` in 1 — sole clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `btn_mode` in 1 — raw button, active-high: cycles the mode.
- `btn_adv` in 1 — raw button: advance the selected field.
- `btn_disp` in 1 — raw button: toggle the display page.
- `en_sec` out 1 — one-cycle seconds enable.
- `sel_min` out 1 — 1 = minutes take seconds carry; 0 = minutes take `set`.
- `sel_hr` out 1 — 1 = hours take minutes carry; 0 = hours take `set`.
- `set` out 1 — one-cycle advance pulse.
- `state` out 1 — display select: 1 = hh:mm, 0 = mm:ss.
- `mode` out 2 — current FSM state, for status LEDs.

## Operation
- All outputs are registered.
- Reset values:
  - `en_sec` = 0, `set` = 0.
  - `sel_min` = 1, `sel_hr` = 1.
  - `state` = 1.
  - `mode` = RUN (2'b00).
  - Prescaler = 0, timeout counter = 0, all synchronizer and edge flops = 0.
- Each button passes through a 2-flop synchronizer, then a rising-edge detector. A press produces one event, regardless of how long it is held.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - The internal `tick` is high when the count equals DIV-1.
  - The prescaler runs in every mode.
- FSM encoding: RUN = 00, SET_MIN = 01, SET_HR = 10. Code 11 is unreachable and recovers to RUN on the next clk.
- RUN:
  - `en_sec` = `tick`, `sel_min` = 1, `sel_hr` = 1.
  - A `btn_disp` event toggles `state`.
  - A `btn_mode` event moves to SET_MIN.
- SET_MIN:
  - `en_sec` = 0 (seconds frozen), `sel_min` = 0, `sel_hr` = 1, `state` forced to 1.
  - A `btn_adv` event gives one `set` pulse.
  - A minutes wrap 59→00 ripples a carry into hours, and this is accepted behaviour.
  - A `btn_mode` event moves to SET_HR.
- SET_HR:
  - `en_sec` = 0, `sel_min` = 1, `sel_hr` = 0, `state` = 1.
  - A `btn_adv` event gives one `set` pulse.
  - A `btn_mode` event moves to RUN.
- Timeout:
  - In SET_MIN and SET_HR, the counter increments on each `tick` and clears on any button event or on a mode change.
  - When the counter reaches TIMEOUT_TICKS, the FSM returns to RUN and the counter clears.
  - On return to RUN, `state` keeps the value it had before set mode was entered. That value is held in a saved flop.
- `btn_disp` is ignored in the set modes.

## Timing
- Button to event: an edge on a raw pin is seen as an event 3 clk after the first clk that samples it high (2 synchronizer flops plus 1 edge flop).
- `set`: asserted in the cycle after the event, for exactly 1 clk. `mode`, `sel_*` and `state` also change in the cycle after their event.
- `en_sec`: a 1-clk pulse every DIV clk while in RUN. The first pulse comes DIV clk after reset release.
- Simultaneous events in one cycle:
  - `btn_mode` takes priority. `btn_adv` is dropped, so no `set` pulse occurs.
  - A timeout and `btn_mode` in the same cycle: the timeout wins and the FSM goes to RUN.
- Select and pulse ordering:
  - `sel_*` switch in the same cycle as `mode`.
  - A `set` pulse never coincides with a `sel_*` change, because adv is dropped on a mode-event cycle.
- Reset mid-operation: every output returns to its reset value asynchronously. The first event is possible 3 clk after release.

## Configuration
- `CLOCK_CTRL_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a counter that must see a stable level for DEB_CYCLES consecutive clk before the filtered level updates.
  - Edge detection acts on the filtered level.
  - Event latency becomes 3 + DEB_CYCLES clk.
- Undefined: no filter. Edges come directly from the synchronizer output and DEB_CYCLES is unused.

## Test plan
Unless stated otherwise, parameters are DIV=4, TIMEOUT_TICKS=3, and the macro is undefined.

- Reset, then idle 20 clk → `en_sec` pulses at clk 4, 8, 12, 16, 20; `sel_min` = `sel_hr` = 1; `state` = 1; `mode` = 00.
- Press `btn_disp` in RUN → `state` toggles 1→0 exactly 4 clk after the press; holding the button 50 clk gives no further toggle.
- Press `btn_mode`, then `btn_adv` twice → `mode` = 01, `sel_min` = 0, `en_sec` stays 0, exactly two 1-clk `set` pulses, `state` = 1.
- From SET_HR, idle → after 3 ticks (12 clk) `mode` = 00, `sel_hr` = 1, `state` restored to its pre-set value, and `en_sec` resumes.
- In SET_MIN, raise `btn_mode` and `btn_adv` on the same clk → `mode` = 10 and no `set` pulse.
- Macro defined with DEB_CYCLES=8: bounce `btn_adv` with a 3-clk on/off pattern in SET_MIN → no `set` pulse; hold it high for 10 clk → one `set` pulse.
